display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 7-segment digits. It shares one instance of the existing 5-bit-code segment decoder among NUM_DIG digit positions. It holds a double-buffered bank of 5-bit digit codes, drives the decoder input, and drives the active-low digit enables. Blank gaps between digits prevent ghosting, and updates are committed tear-free at frame boundaries.

Parameters:
NUM_DIG, 4, number of multiplexed digit positions (≥2)
PRESCALE, 50000, clk cycles each digit is lit (SHOW phase, ≥1)
BLANK_CYC, 500, clk cycles all digits are dark between digits (BLANK phase, ≥1)
BLINK_FRAMES, 64, frames per blink half-period (used only with BLINK_EN)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  scan enable; low forces all digits dark
wr_en  in  1  write wr_data into the shadow bank at wr_addr
wr_addr  in  $clog2(NUM_DIG)  shadow bank index
wr_data  in  5  digit code, same encoding as the decoder input
commit  in  1  pulse: request shadow→active copy at next frame end
blink_mask  in  NUM_DIG  per-digit blink select (BLINK_EN only)
dec_code  out  8  decoder input, {3'b000, code}
an_n  out  NUM_DIG  digit enables, active-low, one-hot-zero or all ones
commit_pending  out  1  commit requested, not yet applied
frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, rst_n=0):
  - shadow and active banks = 0; idx = 0; prescaler = 0; state = BLANK.
  - an_n = all ones; dec_code = 0; commit_pending = 0; frame_tick = 0; blink phase = 0.
- All outputs are registered and change on the same edge as the state/idx update.
- States:
  - BLANK: lasts BLANK_CYC cycles; an_n = all ones; dec_code = {3'b0, active[idx]} (decoder setup).
  - SHOW: lasts PRESCALE cycles; an_n[idx] = 0, all other bits 1; dec_code = {3'b0, active[idx]}.
- Transitions:
  - BLANK→SHOW when the prescaler reaches BLANK_CYC-1.
  - SHOW→BLANK when the prescaler reaches PRESCALE-1; idx increments at the same time.
  - The prescaler clears on each transition.
- Frame wrap: on SHOW→BLANK with idx = NUM_DIG-1:
  - idx becomes 0 and frame_tick = 1 for that cycle.
  - If commit_pending was 1 before the edge, active ← shadow (all entries) and commit_pending ← 0.
- Frame length = NUM_DIG × (PRESCALE + BLANK_CYC) cycles. Scan order is idx 0,1,…,NUM_DIG-1.
- commit sets commit_pending. Repeated commits while pending merge into one.
- A commit in the wrap cycle is not consumed by that wrap: commit_pending stays 1 and the copy happens at the following wrap.
- A write in the wrap cycle lands in shadow only; the copy uses pre-write shadow contents.
- A write with wr_addr ≥ NUM_DIG is ignored. Writes never alter the active bank directly.
- enable low:
  - Next edge: state = BLANK, prescaler = 0, idx held, an_n = all ones.
  - No frame_tick is generated while disabled; commit_pending is retained; writes are still accepted.
- enable rising: a full BLANK phase runs first, then SHOW resumes at the held idx.
- Reset mid-frame discards pending commits and both banks.

Optional Feature:
BLINK_EN
- Defined:
  - A frame counter toggles the blink phase every BLINK_FRAMES frame_ticks.
  - While the phase is 1, a SHOW slot whose blink_mask[idx] = 1 keeps an_n all ones (digit dark).
  - Timing, frame_tick and commit behaviour are unchanged.
- Undefined: blink_mask is ignored; no frame counter is synthesized.

Test Plan:
All scenarios use NUM_DIG=4, PRESCALE=4, BLANK_CYC=1.
- Reset release, enable=1 -> an_n=1111 for 1 cycle, then 1110 for 4 cycles; dec_code=8'h00; frame_tick first high 20 cycles after release.
- Free run of 3 frames -> an_n sequence 1111,1110,1111,1101,1111,1011,1111,0111 repeating; frame_tick exactly once per 20 cycles.
- wr addr2=5'h13, then commit mid-frame -> commit_pending=1 until the next frame_tick, then 0; from that frame on, dec_code=8'h13 while an_n=1011; digit 2 shows 8'h00 before that.
- Commit in the frame_tick cycle, with wr addr1=5'h1F in the same cycle -> pending stays 1; dec_code=8'h1F at an_n=1101 only after the second wrap.
- enable low during SHOW of idx1 for 10 cycles -> next cycle an_n=1111, no frame_tick; enable high -> 1 dark cycle, then an_n=1101 for 4 cycles.
- BLINK_EN, BLINK_FRAMES=2, blink_mask=0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit in 4-5; other digits unaffected.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - write/commit/enable inputs and decoder/anode outputs of the scan controller
interface display_scan_ctrl_if #(
  parameter int NUM_DIG = 4
);
  localparam int IW = $clog2(NUM_DIG);

  logic               enable;
  logic               wr_en;
  logic [IW-1:0]      wr_addr;
  logic [4:0]         wr_data;
  logic               commit;
  logic [NUM_DIG-1:0] blink_mask;
  logic [7:0]         dec_code;
  logic [NUM_DIG-1:0] an_n;
  logic               commit_pending;
  logic               frame_tick;

  modport master (
    output enable, wr_en, wr_addr, wr_data, commit, blink_mask,
    input  dec_code, an_n, commit_pending, frame_tick
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, commit, blink_mask,
    output dec_code, an_n, commit_pending, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan with blank gaps and frame-boundary commit
// Optional blinking of masked digits is built when BLINK_EN is defined.
module display_scan_ctrl #(
  parameter int NUM_DIG      = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_ctrl_if.slave   bus
);
  localparam int IW   = $clog2(NUM_DIG);
  localparam int MAXC = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4:0]         shadow_q [NUM_DIG];
  logic [4:0]         shadow_d [NUM_DIG];
  logic [4:0]         active_q [NUM_DIG];
  logic [4:0]         active_d [NUM_DIG];
  logic               commit_pending_q, commit_pending_d;
  logic               frame_tick_q, frame_tick_d;
  logic [NUM_DIG-1:0] an_n_q, an_n_d;
  logic [7:0]         dec_code_q, dec_code_d;
  logic               wrap;
  logic               blink_dark;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!bus.enable) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == CW'(BLANK_CYC - 1)) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == CW'(PRESCALE - 1)) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        if (idx_q == IW'(NUM_DIG - 1)) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The copy reads shadow_q, so a write in the wrap cycle misses this frame,
  // and a commit in that cycle re-arms the pending flag after it is cleared.
  always_comb begin
    shadow_d         = shadow_q;
    active_d         = active_q;
    commit_pending_d = commit_pending_q;
    if (wrap && commit_pending_q) begin
      active_d         = shadow_q;
      commit_pending_d = 1'b0;
    end
    if (bus.commit) begin
      commit_pending_d = 1'b1;
    end
    if (bus.wr_en && ({1'b0, bus.wr_addr} < (IW + 1)'(NUM_DIG))) begin
      shadow_d[bus.wr_addr] = bus.wr_data;
    end
  end

`ifdef BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    blink_dark = blink_phase_d & bus.blink_mask[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (^bus.blink_mask) ^ (BLINK_FRAMES > 0);
  assign blink_dark   = 1'b0;
`endif

  // Outputs are derived from the next-state values so they move with state/idx.
  always_comb begin
    an_n_d = '1;
    if (state_d == ST_SHOW && !blink_dark) begin
      an_n_d[idx_d] = 1'b0;
    end
    dec_code_d   = {3'b000, active_d[idx_d]};
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_BLANK;
      cnt_q            <= '0;
      idx_q            <= '0;
      shadow_q         <= '{default: '0};
      active_q         <= '{default: '0};
      commit_pending_q <= 1'b0;
      frame_tick_q     <= 1'b0;
      an_n_q           <= '1;
      dec_code_q       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      commit_pending_q <= commit_pending_d;
      frame_tick_q     <= frame_tick_d;
      an_n_q           <= an_n_d;
      dec_code_q       <= dec_code_d;
    end
  end

  assign bus.an_n           = an_n_q;
  assign bus.dec_code       = dec_code_q;
  assign bus.commit_pending = commit_pending_q;
  assign bus.frame_tick     = frame_tick_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed bench with a slot-timeline model of the scan controller
module tb_display_scan_ctrl;
  localparam int N    = 4;
  localparam int PS   = 4;
  localparam int BL   = 1;
  localparam int BF   = 2;
  localparam int SLOT = PS + BL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic started = 1'b0;
  int   g = 0;
  int   tests = 0;
  int   fails = 0;

  display_scan_ctrl_if #(.NUM_DIG(N)) bus ();

  display_scan_ctrl #(
    .NUM_DIG(N), .PRESCALE(PS), .BLANK_CYC(BL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (started) g <= g + 1;

  // Model: position m inside the current digit slot (blank first, then lit).
  int         m, midx, ticks;
  logic       mpend;
  logic [4:0] mshadow [N];
  logic [4:0] mactive [N];
  logic [3:0] e_an;
  logic [7:0] e_dec;
  logic       e_tick;

  task automatic model_reset();
    m = 0; midx = 0; ticks = 0; mpend = 1'b0;
    for (int i = 0; i < N; i++) begin mshadow[i] = 5'h0; mactive[i] = 5'h0; end
    e_an = 4'hF; e_dec = 8'h00; e_tick = 1'b0;
  endtask

  task automatic model_step();
    logic wrapped;
    logic lit;
    wrapped = 1'b0;
    if (!bus.enable) m = 0;
    else if (m == SLOT - 1) begin
      m = 0;
      if (midx == N - 1) begin midx = 0; wrapped = 1'b1; end
      else midx = midx + 1;
    end else m = m + 1;
    if (wrapped && mpend) begin
      for (int i = 0; i < N; i++) mactive[i] = mshadow[i];
      mpend = 1'b0;
    end
    if (bus.commit) mpend = 1'b1;
    if (bus.wr_en && int'(bus.wr_addr) < N) mshadow[bus.wr_addr] = bus.wr_data;
    if (wrapped) ticks = ticks + 1;
    lit = bus.enable && (m >= BL);
`ifdef BLINK_EN
    if (((ticks / BF) % 2) == 1 && bus.blink_mask[midx]) lit = 1'b0;
`endif
    e_an   = lit ? ~(4'b0001 << midx) : 4'hF;
    e_dec  = {3'b000, mactive[midx]};
    e_tick = wrapped;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, g, act, exp);
    end
  endtask

  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      chk("an_n", {4'h0, bus.an_n}, {4'h0, e_an});
      chk("dec_code", bus.dec_code, e_dec);
      chk("frame_tick", {7'h0, bus.frame_tick}, {7'h0, e_tick});
      chk("commit_pending", {7'h0, bus.commit_pending}, {7'h0, mpend});
      case (g)
        0:   begin chk("lit_rst_an", {4'h0, bus.an_n}, 8'h0F); chk("lit_rst_dec", bus.dec_code, 8'h00); end
        1:   chk("lit_first_show", {4'h0, bus.an_n}, 8'h0E);
        4:   chk("lit_show_end", {4'h0, bus.an_n}, 8'h0E);
        5:   chk("lit_gap", {4'h0, bus.an_n}, 8'h0F);
        6:   chk("lit_dig1", {4'h0, bus.an_n}, 8'h0D);
        19:  chk("lit_no_tick", {7'h0, bus.frame_tick}, 8'h00);
        20:  chk("lit_tick1", {7'h0, bus.frame_tick}, 8'h01);
        28:  chk("lit_pend_set", {7'h0, bus.commit_pending}, 8'h01);
        32:  begin chk("lit_d2_old_an", {4'h0, bus.an_n}, 8'h0B); chk("lit_d2_old", bus.dec_code, 8'h00); end
        40:  chk("lit_pend_clr", {7'h0, bus.commit_pending}, 8'h00);
`ifdef BLINK_EN
        41:  chk("lit_blink_dark", {4'h0, bus.an_n}, 8'h0F);
`else
        41:  chk("lit_blink_off", {4'h0, bus.an_n}, 8'h0E);
`endif
        52:  begin chk("lit_d2_new_an", {4'h0, bus.an_n}, 8'h0B); chk("lit_d2_new", bus.dec_code, 8'h13); end
        60:  chk("lit_wrap_commit", {7'h0, bus.commit_pending}, 8'h01);
        67:  chk("lit_d1_prewrite", bus.dec_code, 8'h00);
        80:  chk("lit_pend_clr2", {7'h0, bus.commit_pending}, 8'h00);
        87:  begin chk("lit_d1_new_an", {4'h0, bus.an_n}, 8'h0D); chk("lit_d1_new", bus.dec_code, 8'h1F); end
        108: chk("lit_dis_dark", {4'h0, bus.an_n}, 8'h0F);
        112: chk("lit_dis_pend", {7'h0, bus.commit_pending}, 8'h01);
        117: chk("lit_resume_gap", {4'h0, bus.an_n}, 8'h0F);
        118: chk("lit_resume_d1", {4'h0, bus.an_n}, 8'h0D);
        120: chk("lit_no_tick_dis", {7'h0, bus.frame_tick}, 8'h00);
        132: chk("lit_tick_shift", {7'h0, bus.frame_tick}, 8'h01);
        150: chk("lit_d3_dis_wr", bus.dec_code, 8'h0A);
        154: chk("lit_pend_prerst", {7'h0, bus.commit_pending}, 8'h01);
        156: begin chk("lit_rst_pend", {7'h0, bus.commit_pending}, 8'h00); chk("lit_rst_an2", {4'h0, bus.an_n}, 8'h0F); end
        169: begin chk("lit_rst_bank_an", {4'h0, bus.an_n}, 8'h0B); chk("lit_rst_bank", bus.dec_code, 8'h00); end
        default: ;
      endcase
    end
  end

  task automatic at_edge(input int k);
    while (g < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.enable = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 5'h0;
    bus.commit = 1'b0; bus.blink_mask = 4'b0001;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; started = 1'b1;
    at_edge(25);  bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 5'h13;
    at_edge(26);  bus.wr_en = 1'b0;
    at_edge(27);  bus.commit = 1'b1;
    at_edge(28);  bus.commit = 1'b0;
    at_edge(45);  bus.commit = 1'b1;
    at_edge(46);  bus.commit = 1'b0;
    at_edge(59);  bus.commit = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 5'h1F;
    at_edge(60);  bus.commit = 1'b0; bus.wr_en = 1'b0;
    at_edge(107); bus.enable = 1'b0;
    at_edge(109); bus.commit = 1'b1;
    at_edge(110); bus.commit = 1'b0;
    at_edge(111); bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 5'h0A;
    at_edge(112); bus.wr_en = 1'b0;
    at_edge(117); bus.enable = 1'b1;
    at_edge(153); bus.commit = 1'b1;
    at_edge(154); bus.commit = 1'b0;
    at_edge(155); rst_n = 1'b0;
    at_edge(157); rst_n = 1'b1;
    at_edge(185);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
